mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO registers, sitting in the EX stage beside the ALU and consuming the same ID/EX pipeline-register outputs. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While an operation is in flight it raises a stall request so the front end (PC, IF/ID, ID/EX) holds.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid this cycle (decoded in ID, registered by ID/EX).
- `op`  in  3  3'b000 MULT, 3'b001 MULTU, 3'b010 DIV, 3'b011 DIVU, 3'b100 MTHI, 3'b101 MTLO; other codes ignored.
- `src1`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `src2`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  cancel in-flight op; HI/LO untouched.
- `busy`  out  1  stall request to PC, IF/ID, ID/EX.
- `done`  out  1  one-cycle pulse: HI/LO updated in this cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC. 6-bit iteration counter; latched operands, sign flags and op.
- IDLE + `start` + MULT/MULTU/DIV/DIVU + !`flush`: latch |src1|, |src2| (signed ops) or raw (unsigned ops), result signs, go to CALC, counter = 0.
- IDLE + `start` + MTHI/MTLO + !`flush`: write `src1` to HI/LO at that edge; no CALC, `busy` stays 0.
- CALC multiply: shift-add, one multiplier bit per cycle, 64-bit product.
- CALC divide: restoring division, one quotient bit per cycle; LO = quotient, HI = remainder.
- Signed fix-up on write: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
- Divide by zero (`src2` = 0, DIV or DIVU): full latency; LO = 32'hFFFF_FFFF, HI = `src1`.
- Signed overflow 32'h8000_0000 / -1: LO = 32'h8000_0000, HI = 0.
- CALC finishes at counter = 31: HI/LO written, return to IDLE.
- `start` while in CALC: ignored (ID/EX is stalled, so it is held until accepted).
- `flush` in CALC: next state IDLE, HI/LO unchanged, no `done`.
- `flush` and `start` same cycle: flush wins, op discarded.
- Invalid `op` codes: no effect, no `busy`, no `done`.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, counter 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
- `busy` = (state == CALC) | (`start` & op is mul/div & !`flush`); the combinational term stalls in the issue cycle.
- Cycle 0 = issue cycle. Mul/div occupy CALC during cycles 1..32, `busy` = 1 in cycles 0..32.
- HI/LO written at the end of cycle 32; `done` = 1 and new `hi`/`lo` visible in cycle 33; `busy` = 0 in cycle 33.
- MTHI/MTLO: written at the end of cycle 0; `done` = 1 in cycle 1.
- `done` is registered, exactly one cycle wide. A new op may issue in the `done` cycle.
- Reset mid-CALC aborts immediately. No `done` and HI/LO reset to 0.

## Configuration
- `MDU_FAST_MUL_EN` defined: MULT/MULTU use a single-cycle 32x32 multiplier. CALC lasts one cycle (cycle 1), HI/LO written end of cycle 1, `done` in cycle 2. Division is unchanged.
- Undefined: multiply is iterative with 32-cycle latency, identical to divide.

## Test plan
- MULTU 32'hFFFF_FFFF × 32'h0000_0002 -> HI = 32'h1, LO = 32'hFFFF_FFFE. `done` in cycle 33, or cycle 2 with `MDU_FAST_MUL_EN`. `busy` high through cycle 32 (or 1).
- DIV -7 / 2 -> LO = 32'hFFFF_FFFD (-3), HI = 32'hFFFF_FFFF (-1). DIVU 100 / 7 -> LO = 14, HI = 2. Both with `done` in cycle 33.
- DIVU 5 / 0 -> LO = 32'hFFFF_FFFF, HI = 5 after full latency.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO = 32'h8000_0000, HI = 0.
- MTHI 32'hDEAD_BEEF then MTLO 32'h1234_5678 on consecutive cycles -> `busy` never high, `done` pulses in cycles 1 and 2, final HI/LO as written.
- Abort cases:
  - DIVU issued, `flush` in cycle 10 -> `busy` low from cycle 11, no `done`, prior HI/LO retained.
  - `rst` low in cycle 5 -> HI = LO = 0 immediately.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle. MTHI/MTLO write HI/LO directly.
// Optional build macro MDU_FAST_MUL_EN swaps the iterative multiply for a
// single-cycle 32x32 multiplier. Division is unaffected by the macro.
module mdu_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t      state_reg;
    logic [5:0]  count_reg;
    logic [63:0] acc_reg;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opb_reg;      // mul: multiplicand; div: divisor
    logic        is_div_reg;
    logic        neg_q_reg;    // product/quotient negated on write
    logic        neg_r_reg;    // remainder takes dividend sign
    logic        div_zero_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // Op decode and operand magnitudes for the issue cycle
    logic        is_mul, is_div, is_signed;
    logic [31:0] a_abs, b_abs;

    assign is_mul    = (op == 3'b000) || (op == 3'b001);
    assign is_div    = (op == 3'b010) || (op == 3'b011);
    assign is_signed = !op[0];
    assign a_abs     = (is_signed && src1[31]) ? (32'd0 - src1) : src1;
    assign b_abs     = (is_signed && src2[31]) ? (32'd0 - src2) : src2;

    // One shift-add multiply step: add multiplicand if LSB set, shift right
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
    assign mul_next = {mul_sum, acc_reg[31:1]};

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    assign div_trial = {acc_reg[63:32], acc_reg[31]};
    assign div_ge    = div_trial >= {1'b0, opb_reg};
    assign div_diff  = div_trial[31:0] - opb_reg;
    assign div_next  = {(div_ge ? div_diff : div_trial[31:0]), acc_reg[30:0], div_ge};

    logic [63:0] step_next;
    assign step_next = is_div_reg ? div_next : mul_next;

    // Final raw result and the condition that ends CALC
    logic        last_step;
    logic [63:0] final_acc;
`ifdef MDU_FAST_MUL_EN
    assign last_step = is_div_reg ? (count_reg == 6'd31) : 1'b1;
    assign final_acc = is_div_reg ? div_next
                                  : ({32'd0, opb_reg} * {32'd0, acc_reg[31:0]});
`else
    assign last_step = (count_reg == 6'd31);
    assign final_acc = step_next;
`endif

    // Signed fix-up; divide-by-zero forces LO to all ones, and HI naturally
    // becomes src1 because |src1| is restored to the dividend's sign.
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    assign prod_fix = neg_q_reg ? (64'd0 - final_acc) : final_acc;
    assign quot_fix = div_zero_reg ? 32'hFFFF_FFFF
                    : (neg_q_reg ? (32'd0 - final_acc[31:0]) : final_acc[31:0]);
    assign rem_fix  = neg_r_reg ? (32'd0 - final_acc[63:32]) : final_acc[63:32];

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= 6'd0;
            acc_reg      <= 64'd0;
            opb_reg      <= 32'd0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (is_mul || is_div) begin
                            state_reg    <= S_CALC;
                            count_reg    <= 6'd0;
                            acc_reg      <= {32'd0, (is_div ? a_abs : b_abs)};
                            opb_reg      <= is_div ? b_abs : a_abs;
                            is_div_reg   <= is_div;
                            neg_q_reg    <= is_signed && (src1[31] ^ src2[31]);
                            neg_r_reg    <= is_signed && src1[31];
                            div_zero_reg <= is_div && (src2 == 32'd0);
                        end else if (op == 3'b100) begin
                            hi_reg   <= src1;
                            done_reg <= 1'b1;
                        end else if (op == 3'b101) begin
                            lo_reg   <= src1;
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_reg <= S_IDLE;
                    end else if (last_step) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                        if (is_div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end else begin
                            hi_reg <= prod_fix[63:32];
                            lo_reg <= prod_fix[31:0];
                        end
                    end else begin
                        acc_reg   <= step_next;
                        count_reg <= count_reg + 6'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Stall covers the issue cycle combinationally, then CALC
    assign busy = (state_reg == S_CALC) || (start && (is_mul || is_div) && !flush);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed-vector bench for mdu_hilo with hand-computed results.
module tb_mdu_hilo;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    mdu_hilo dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .src1 (src1),
        .src2 (src2),
        .flush(flush),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Issue one mul/div op and follow it to done; checks latency, busy profile, result
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
        int cyc;
        logic busy_ok;
        @(posedge clk); #1;
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busyrun"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busydone"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;

        // Multiply / divide vectors
        run_op("multu_ff_x2", 3'b001, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mult_m3x5",   3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
        run_op("div_m7_2",    3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_7_m2",    3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_100_7",  3'b011, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
        run_op("divu_5_0",    3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
        run_op("div_m9_0",    3'b010, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, DIV_LAT);
        run_op("div_ovf",     3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);

        // MTHI then MTLO back to back
        @(posedge clk); #1;
        start = 1'b1; op = 3'b100; src1 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_busy0", 64'(busy), 64'd0);
        @(posedge clk); #1;
        op = 3'b101; src1 = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_done1", 64'(done), 64'd1);
        chk("mtlo_busy1", 64'(busy), 64'd0);
        chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("mtlo_done2", 64'(done), 64'd1);
        chk("mtlo_lo", 64'(lo), 64'h1234_5678);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mt_done3", 64'(done), 64'd0);

        // Flush in cycle 10 of a DIVU
        begin
            logic seen;
            @(posedge clk); #1;
            start = 1'b1; op = 3'b011; src1 = 32'd100; src2 = 32'd3;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #1 flush = 1'b1;
            @(negedge clk);
            chk("flush_busy10", 64'(busy), 64'd1);
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            chk("flush_busy11", 64'(busy), 64'd0);
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("flush_nodone", 64'(seen), 64'd0);
            chk("flush_hi", 64'(hi), 64'hDEAD_BEEF);
            chk("flush_lo", 64'(lo), 64'h1234_5678);
        end

        // Flush and start together: op discarded
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'b001; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        chk("fs_busy0", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("fs_busy1", 64'(busy), 64'd0);
        chk("fs_done1", 64'(done), 64'd0);

        // Invalid op code
        @(posedge clk); #1;
        start = 1'b1; op = 3'b110; src1 = 32'h5555_5555;
        @(negedge clk);
        chk("inv_busy0", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("inv_done1", 64'(done), 64'd0);
        chk("inv_hi", 64'(hi), 64'hDEAD_BEEF);

        // Reset in cycle 5 of a DIVU
        begin
            logic seen;
            @(posedge clk); #1;
            start = 1'b1; op = 3'b011; src1 = 32'd100; src2 = 32'd7;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1 rst = 1'b0;
            #1;
            chk("rstmid_hi", 64'(hi), 64'd0);
            chk("rstmid_lo", 64'(lo), 64'd0);
            chk("rstmid_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            rst = 1'b1;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            chk("rstmid_quiet", 64'(seen), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
